apb_slave_mem: RTL

//  APB completer for the psel1/psel2 targets driven by the apb_pkg master FSM.

---
 rtl/apb_slave_mem.sv | 101 ++++++++++
 1 files changed

// File: rtl/apb_slave_mem.sv
// APB completer with a small local register memory, programmable wait states,
// out-of-range error response and a saturating error counter.
module apb_slave_mem #(
  parameter int ADDR_WIDTH  = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int MEM_DEPTH   = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr,
  output logic [7:0]            err_count
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef enum logic [1:0] {SLAVE_IDLE, SLAVE_WRITE, SLAVE_READ} apb_slave_state_t;

  apb_slave_state_t        state_q, state_d;
  logic [3:0]              wait_cnt_q, wait_cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0]   mem_q [MEM_DEPTH];
  logic [7:0]              err_count_q;

  logic                    in_range;
  logic [IDX_W-1:0]        idx;
  logic                    mem_we;
  logic                    err_inc;

  assign in_range  = ({1'b0, addr_q} < (ADDR_WIDTH+1)'(MEM_DEPTH));
  assign idx       = addr_q[IDX_W-1:0];
  assign err_count = err_count_q;

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) state_q <= SLAVE_IDLE;
    else        state_q <= state_d;
  end

  // Only the address phase is captured; the bus may change freely during access.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    pwrite_d   = pwrite_q;
    case (state_q)
      SLAVE_IDLE: begin
        if (psel && !penable) begin
          addr_d     = paddr;
          wdata_d    = pwdata;
          pwrite_d   = pwrite;
          wait_cnt_d = 4'(WAIT_STATES);
          state_d    = pwrite ? SLAVE_WRITE : SLAVE_READ;
        end
      end
      default: begin
        if (!psel)                 state_d    = SLAVE_IDLE;
        else if (wait_cnt_q != '0) wait_cnt_d = wait_cnt_q - 4'd1;
        else if (penable)          state_d    = SLAVE_IDLE;
      end
    endcase
  end

  always_comb begin
    pready  = (state_q != SLAVE_IDLE) && psel && penable && (wait_cnt_q == '0);
    pslverr = pready && !in_range;
    prdata  = '0;
    if (pready && !pwrite_q && in_range) prdata = mem_q[idx];
  end

  assign mem_we  = pready && pwrite_q && in_range;
  assign err_inc = pslverr && (err_count_q != 8'hFF);

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      wait_cnt_q  <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      pwrite_q    <= 1'b0;
      err_count_q <= '0;
      for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      pwrite_q   <= pwrite_d;
      if (err_inc) err_count_q <= err_count_q + 8'd1;
      if (mem_we)  mem_q[idx]  <= wdata_q;
    end
  end

endmodule
